// File: rtl/spi_burst_ram_slave.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : spi_burst_ram_slave                                           |
// | Purpose  : SPI slave (ss_n / MOSI sampled on rising clk) fronting an     |
// |            internal MEM_DEPTH x DATA_W single-port RAM, with optional    |
// |            auto-increment burst addressing, frame-abort detection and    |
// |            a busy flag.                                                  |
// | Ports    : clk       - system clock, rising edge                         |
// |            rst       - synchronous active-high reset                     |
// |            ss_n      - slave select, active low, one frame per low period|
// |            MOSI      - serial in, MSB first                              |
// |            MISO      - serial out, registered, 0 outside read-out        |
// |            busy      - registered, high whenever the FSM is not idle     |
// |            frame_err - registered one-cycle pulse on an aborted frame    |
// | Frame    : 1 start edge, 2 command bits, P payload bits; a read-data     |
// |            command then adds 1 fetch edge and DATA_W read-out edges.     |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module spi_burst_ram_slave #(
  parameter int ADDR_SIZE = 8,
  parameter int DATA_W    = 8,
  parameter int MEM_DEPTH = 256,
  parameter bit AUTO_INC  = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic ss_n,
  input  logic MOSI,
  output logic MISO,
  output logic busy,
  output logic frame_err
);

  // Payload shifter is sized for the longer of the two payload kinds.
  localparam int c_pw = (ADDR_SIZE > DATA_W) ? ADDR_SIZE : DATA_W;
  localparam int c_cw = $clog2(c_pw + 1) + 1;
  localparam int c_mw = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  localparam logic [c_cw-1:0]      c_addr_last = c_cw'(ADDR_SIZE - 1);
  localparam logic [c_cw-1:0]      c_data_last = c_cw'(DATA_W - 1);
  localparam logic [c_cw-1:0]      c_data_w    = c_cw'(DATA_W);
  localparam logic [ADDR_SIZE:0]   c_depth     = (ADDR_SIZE + 1)'(MEM_DEPTH);
  localparam logic [ADDR_SIZE-1:0] c_last_addr = ADDR_SIZE'(MEM_DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CMD     = 3'd1,
    S_PAYLOAD = 3'd2,
    S_FETCH   = 3'd3,
    S_TX      = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t                state_q, state_d;
  logic [c_cw-1:0]       cnt_q, cnt_d;
  logic [1:0]            cmd_q, cmd_d;
  logic [c_pw-2:0]       shift_q, shift_d;
  logic [DATA_W-1:0]     tx_q, tx_d;
  logic [ADDR_SIZE-1:0]  wr_addr_q, wr_addr_d;
  logic [ADDR_SIZE-1:0]  rd_addr_q, rd_addr_d;
  logic                  miso_q, miso_d;
  logic                  busy_q, busy_d;
  logic                  ferr_q, ferr_d;

  logic [DATA_W-1:0]     mem [MEM_DEPTH];
  logic                  mem_we;
  logic [ADDR_SIZE-1:0]  mem_wa;
  logic [DATA_W-1:0]     mem_wd;

  logic [c_pw-1:0]       w_shift_in;
  logic [c_cw-1:0]       w_plen_last;
  logic [DATA_W-1:0]     w_rd_word;

  function automatic logic in_range(input logic [ADDR_SIZE-1:0] a);
    return {1'b0, a} < c_depth;
  endfunction

  function automatic logic [ADDR_SIZE-1:0] next_addr(input logic [ADDR_SIZE-1:0] a);
    return (a == c_last_addr) ? '0 : a + 1'b1;
  endfunction

  // Full payload including the bit being sampled on this edge.
  assign w_shift_in  = {shift_q, MOSI};
  // cmd[0] selects a data payload (01/11) versus an address payload (00/10).
  assign w_plen_last = cmd_q[0] ? c_data_last : c_addr_last;
  // Out-of-range reads return zeros instead of indexing past the array.
  assign w_rd_word   = in_range(rd_addr_q) ? mem[rd_addr_q[c_mw-1:0]] : '0;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cmd_d     = cmd_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    wr_addr_d = wr_addr_q;
    rd_addr_d = rd_addr_q;
    miso_d    = miso_q;
    ferr_d    = 1'b0;
    mem_we    = 1'b0;
    mem_wa    = wr_addr_q;
    mem_wd    = w_shift_in[DATA_W-1:0];

    unique case (state_q)
      S_IDLE: begin
        miso_d = 1'b0;
        cnt_d  = '0;
        if (!ss_n) state_d = S_CMD;
      end

      S_CMD: begin
        if (ss_n) begin
          state_d = S_IDLE;
          miso_d  = 1'b0;
          ferr_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cmd_d = {cmd_q[0], MOSI};
          if (cnt_q == '0) begin
            cnt_d = 1;
          end else begin
            cnt_d   = '0;
            state_d = S_PAYLOAD;
          end
        end
      end

      S_PAYLOAD: begin
        if (ss_n) begin
          state_d = S_IDLE;
          miso_d  = 1'b0;
          ferr_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          shift_d = w_shift_in[c_pw-2:0];
          if (cnt_q == w_plen_last) begin
            cnt_d   = '0;
            state_d = S_DONE;
            unique case (cmd_q)
              2'b00: wr_addr_d = w_shift_in[ADDR_SIZE-1:0];
              2'b01: begin
                // Out-of-range writes are dropped but the pointer still advances.
                mem_we = in_range(wr_addr_q);
                if (AUTO_INC) wr_addr_d = next_addr(wr_addr_q);
              end
              2'b10: rd_addr_d = w_shift_in[ADDR_SIZE-1:0];
              default: state_d = S_FETCH;
            endcase
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      S_FETCH: begin
        if (ss_n) begin
          state_d = S_IDLE;
          miso_d  = 1'b0;
          ferr_d  = 1'b1;
        end else begin
          tx_d    = w_rd_word;
          cnt_d   = '0;
          state_d = S_TX;
        end
      end

      S_TX: begin
        // All bits already shifted out: this edge only closes the read-out,
        // so a frame whose ss_n rises here is treated as complete.
        if (cnt_q == c_data_w) begin
          miso_d  = 1'b0;
          cnt_d   = '0;
          state_d = S_DONE;
          if (AUTO_INC) rd_addr_d = next_addr(rd_addr_q);
        end else if (ss_n) begin
          state_d = S_IDLE;
          miso_d  = 1'b0;
          ferr_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          miso_d = tx_q[DATA_W-1];
          tx_d   = {tx_q[DATA_W-2:0], 1'b0};
          cnt_d  = cnt_q + 1'b1;
        end
      end

      S_DONE: begin
        miso_d = 1'b0;
        if (ss_n) state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        miso_d  = 1'b0;
        cnt_d   = '0;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      cmd_q     <= '0;
      shift_q   <= '0;
      tx_q      <= '0;
      wr_addr_q <= '0;
      rd_addr_q <= '0;
      miso_q    <= 1'b0;
      busy_q    <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cmd_q     <= cmd_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      wr_addr_q <= wr_addr_d;
      rd_addr_q <= rd_addr_d;
      miso_q    <= miso_d;
      busy_q    <= busy_d;
      ferr_q    <= ferr_d;
    end
  end

  // RAM has no reset; a reset on the final payload edge still cancels the write.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) mem[mem_wa[c_mw-1:0]] <= mem_wd;
  end

  assign MISO      = miso_q;
  assign busy      = busy_q;
  assign frame_err = ferr_q;

endmodule
`default_nettype wire
